// File: rtl/sipo_rotate_rx.sv
// sipo_rotate_rx: rebuilds DW-bit words from a rotate-register serial link.
// Define PARITY_CHK_EN to expect a trailing even-parity bit per word.
module sipo_rotate_rx #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          async_rst_n,
  input  logic          dir,
  input  logic          sin_valid,
  input  logic          sin,
  input  logic          clear,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
`ifdef PARITY_CHK_EN
  output logic          par_err,
`endif
  output logic          busy,
  output logic          ovf
);

  localparam int CW = $clog2(DW + 1);
`ifdef PARITY_CHK_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t        state;
  logic [DW-1:0] sh;
  logic [CW-1:0] cnt;
  logic          dir_q;

  logic          cur_dir;
  logic [DW-1:0] sh_nxt;
  logic [DW-1:0] word;
  logic          room;

  always_comb begin
    cur_dir = (state == IDLE) ? dir : dir_q;
    sh_nxt  = cur_dir ? {sin, sh[DW-1:1]}
                      : {sh[DW-2:0], sin};
`ifdef PARITY_CHK_EN
    // Parity bit is never shifted in.
    word    = sh;
`else
    word    = sh_nxt;
`endif
    room    = !dout_valid || dout_ready;
  end

  assign busy = (state == RECV);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
`ifdef PARITY_CHK_EN
      par_err    <= 1'b0;
`endif
    end else begin
      if (dout_valid && dout_ready)
        dout_valid <= 1'b0;
      if (clear) begin
        state <= IDLE;
        sh    <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (sin_valid) begin
        unique case (state)
          IDLE: begin
            dir_q <= dir;
            sh    <= sh_nxt;
            cnt   <= CW'(1);
            state <= RECV;
          end
          RECV: begin
            if (cnt == LAST) begin
              sh    <= '0;
              cnt   <= '0;
              state <= IDLE;
              if (room) begin
                dout       <= word;
                dout_valid <= 1'b1;
`ifdef PARITY_CHK_EN
                par_err    <= (^sh) ^ sin;
`endif
              end else begin
                ovf <= 1'b1;
              end
            end else begin
              sh  <= sh_nxt;
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_rotate_rx.sv
// Scoreboard bench for sipo_rotate_rx against a bit-queue reference model.
// Build with PARITY_CHK_EN to cover the parity variant.
module tb_sipo_rotate_rx;

  localparam int DW = 4;
`ifdef PARITY_CHK_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  logic dir = 1'b0;
  logic sin_valid = 1'b0;
  logic sin = 1'b0;
  logic clear = 1'b0;
  logic dout_ready = 1'b0;
  logic [DW-1:0] dout;
  logic dout_valid;
  logic busy;
  logic ovf;
`ifdef PARITY_CHK_EN
  logic par_err;
`endif

  always #5 clk = ~clk;

  sipo_rotate_rx #(.DW(DW)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .dir        (dir),
    .sin_valid  (sin_valid),
    .sin        (sin),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef PARITY_CHK_EN
    .par_err    (par_err),
`endif
    .busy       (busy),
    .ovf        (ovf)
  );

  typedef struct {
    logic [DW-1:0] w;
    logic          pe;
  } exp_t;

  int   checks = 0;
  int   passes = 0;
  exp_t expq[$];
  bit   mq[$];
  bit   mdir = 1'b0;
  bit   mfull = 1'b0;
  bit   movf = 1'b0;
  exp_t me;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  // Reference: collect bits, build the word once NB bits are in.
  task automatic model_cycle(input bit sv, input bit s, input bit d,
                             input bit clr, input bit rdy);
    bit   consumed;
    bit   done;
    exp_t e;
    consumed = mfull && rdy;
    done = 1'b0;
    e.w = '0;
    e.pe = 1'b0;
    if (clr) begin
      mq.delete();
      movf = 1'b0;
    end else if (sv) begin
      if (mq.size() == 0) mdir = d;
      mq.push_back(s);
      if (mq.size() == NB) begin
        for (int i = 0; i < DW; i++) begin
          if (mdir) e.w[i] = mq[i];
          else e.w[DW-1-i] = mq[i];
        end
        if (NB > DW) e.pe = (^e.w) ^ mq[NB-1];
        mq.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!mfull || rdy) begin
        expq.push_back(e);
        mfull = 1'b1;
      end else begin
        movf = 1'b1;
      end
    end else if (consumed) begin
      mfull = 1'b0;
    end
  endtask

  task automatic step(input bit sv, input bit s, input bit d,
                      input bit clr, input bit rdy);
    @(posedge clk);
    #1;
    chk("busy", busy, 32'(mq.size() != 0));
    chk("dout_valid", dout_valid, mfull);
    chk("ovf", ovf, movf);
    sin_valid = sv;
    sin = s;
    dir = d;
    clear = clr;
    dout_ready = rdy;
    model_cycle(sv, s, d, clr, rdy);
  endtask

  task automatic send(input logic [DW-1:0] w, input bit d,
                      input int gapmax, input int rdy_pct,
                      input bit bad_par);
    bit b;
    int g;
    for (int i = 0; i < NB; i++) begin
      g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
      repeat (g)
        step(1'b0, 1'($urandom), 1'($urandom), 1'b0,
             $urandom_range(99, 0) < rdy_pct);
      if (i == DW) b = (^w) ^ bad_par;
      else b = d ? w[i] : w[DW-1-i];
      step(1'b1, b, (i == 0) ? d : 1'($urandom), 1'b0,
           $urandom_range(99, 0) < rdy_pct);
    end
  endtask

  always @(negedge clk) begin
    if (async_rst_n && dout_valid && dout_ready) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL word: got %0h want none", dout);
      end else begin
        me = expq.pop_front();
        chk("word", dout, me.w);
`ifdef PARITY_CHK_EN
        chk("par_err", par_err, me.pe);
`endif
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    async_rst_n = 1'b1;

    // MSB-first
    send(4'b1011, 1'b0, 0, 100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("msb_dout", dout, 4'b1011);

    // LSB-first, gap, dir flip mid-word
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef PARITY_CHK_EN
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lsb_dout", dout, 4'b1011);
    chk("lsb_ovf", ovf, 0);

    // Backpressure
    send(4'hA, 1'b0, 0, 0, 1'b0);
    send(4'h5, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_dout", dout, 4'hA);
    chk("bp_ovf", ovf, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_valid", dout_valid, 0);
    chk("bp_ovf_held", ovf, 1);

    // Async reset mid-word with a word pending
    send(4'h9, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    async_rst_n = 1'b0;
    sin_valid = 1'b0;
    mq.delete();
    mfull = 1'b0;
    movf = 1'b0;
    expq.delete();
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk);
    async_rst_n = 1'b1;
    send(4'b1100, 1'b0, 0, 100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("arst_word", dout, 4'b1100);

    // Abort, with ovf set beforehand
    send(4'h3, 1'b1, 0, 0, 1'b0);
    send(4'hC, 1'b1, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    send(4'b0110, 1'b0, 0, 100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_dout", dout, 4'b0110);
    chk("abort_ovf", ovf, 0);

`ifdef PARITY_CHK_EN
    send(4'b1011, 1'b0, 0, 100, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("par_bad", par_err, 1);
`endif

    // Random words
    for (int n = 0; n < 60; n++)
      send(DW'($urandom), 1'($urandom), 2,
           $urandom_range(100, 20), 1'($urandom));

    // Random raw cycles, including clears
    for (int n = 0; n < 1500; n++)
      step($urandom_range(3, 0) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(39, 0) == 0, $urandom_range(2, 0) != 0);

    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drained", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sipo_rotate_rx.md
Name: sipo_rotate_rx

Overview:
- Serial-in parallel-out receiver: the far end of a rotate-register serial link.
- The transmit side loads a DW-bit word into a universal rotate register and shifts it out, one bit per cycle:
  - left rotate gives MSB-first, tapped at q[DW-1];
  - right rotate gives LSB-first, tapped at q[0].
- This block reassembles those bits into DW-bit words and presents them on a valid/ready output port.
- It has a single-entry output buffer and a sticky overflow flag.

Parameters:
- DW, 4: word width in bits. Legal range is DW >= 2.
- CW, $clog2(DW+1): width of the bit counter. This is a derived localparam, not overridable.

Ports:
- clk, input, 1: rising-edge clock.
- async_rst_n, input, 1: asynchronous active-low reset.
- dir, input, 1: bit order. 0 = MSB-first (left rotate); 1 = LSB-first (right rotate).
- sin_valid, input, 1: sin carries a valid bit this cycle.
- sin, input, 1: serial data bit.
- clear, input, 1: synchronous abort of the partial word and clear of ovf.
- dout, output, DW: assembled word.
- dout_valid, output, 1: dout holds an unconsumed word.
- dout_ready, input, 1: consumer accepts dout when high together with dout_valid.
- busy, output, 1: a word is partially received.
- ovf, output, 1: sticky flag; at least one completed word was dropped.

Behaviour:
- Reset (async_rst_n=0, asynchronous) forces:
  - state=IDLE, sh=0, cnt=0, dir_q=0;
  - dout=0, dout_valid=0, busy=0, ovf=0.
- Release of reset is synchronous to clk. A reset mid-word discards the partial word.
- FSM states:
  - IDLE: cnt=0, busy=0.
  - RECV: 0<cnt<DW, busy=1.
- IDLE transition: on sin_valid, latch dir_q<=dir, shift in the first bit, set cnt<=1, go to RECV.
- dir is sampled only on the first bit of each word. dir changes mid-word are ignored.
- Shift rules:
  - dir_q=0: sh <= {sh[DW-2:0], sin}.
  - dir_q=1: sh <= {sin, sh[DW-1:1]}.
- sin_valid=0 holds sh, cnt and state. Gaps between bits are allowed.
- Word completion happens when sin_valid=1 and cnt==DW-1:
  - the shifted value goes directly to dout; there is no extra cycle;
  - cnt<=0, state->IDLE.
- Latency: dout_valid rises on the clock edge that samples the last bit.
- Output handshake: transfer occurs when dout_valid && dout_ready. With no new completion, dout_valid<=0 and dout holds its value.
- Completion with a free buffer loads dout and sets dout_valid<=1. "Free" means dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle. In the second case there is no bubble and dout_valid stays 1.
- Completion with a full buffer (dout_valid=1, dout_ready=0):
  - the new word is dropped;
  - dout keeps the old word;
  - ovf<=1;
  - the receiver still returns to IDLE.
- ovf is cleared only by reset or clear.
- clear:
  - sh<=0, cnt<=0, state->IDLE, ovf<=0;
  - dout and dout_valid are unaffected;
  - clear has priority over sin_valid in the same cycle, so that bit is discarded.
- Back-to-back words with sin_valid held high are accepted with no dead cycle. A new word's first bit is taken in the cycle after the previous word's last bit.

Optional Feature:
- PARITY_CHK_EN defined:
  - each word is followed by one even-parity bit, so completion occurs at cnt==DW;
  - the parity bit is not shifted into sh;
  - an extra output par_err (1 bit) is loaded with dout and valid with dout_valid;
  - par_err=1 when (^word)^parity_bit != 0;
  - reset value of par_err is 0;
  - on overflow, par_err is not updated.
- PARITY_CHK_EN undefined: no par_err port and no parity bit; completion occurs at cnt==DW-1.

Test Plan:
- Reset and idle: assert async_rst_n=0 mid-cycle -> dout=0, dout_valid=0, busy=0, ovf=0 immediately, without waiting for a clock edge.
- MSB-first: dir=0, sin=1,0,1,1 on consecutive cycles with dout_ready=1 -> dout=4'b1011 and dout_valid=1 after the 4th edge; busy=1 after edges 1-3.
- LSB-first with gaps and a mid-word dir change:
  - stimulus: dir=1, sin=1,1,(gap),0,1, with dir driven to 0 after the 2nd bit;
  - required: dout=4'b1011, no ovf.
- Backpressure:
  - stimulus: dout_ready=0, send 4'hA then 4'h5 back-to-back;
  - required: dout stays 4'hA, ovf=1;
  - then: raise dout_ready for 1 cycle -> dout_valid=0, ovf stays 1.
- Abort:
  - stimulus: 2 bits, then clear=1 with sin_valid=1, then bits 0,1,1,0 (dir=0);
  - required: dout=4'b0110, ovf=0.
- Async reset after 3 bits, then a full word 4'b1100 -> dout=4'b1100. With PARITY_CHK_EN: send 4'b1011 with parity 0 -> par_err=1.
